// File: rtl/cpu31_pkg.sv
// Shared definitions for the 31-instruction CPU: opcode/funct encodings,
// one-hot bit positions used by the decode stage and the controller.
package cpu31_pkg;

    localparam int NUM_INSTR = 31;

    // Primary opcodes, instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type function codes, instr[5:0]
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_SLLV = 6'b000100;
    localparam logic [5:0] F_SRLV = 6'b000110;
    localparam logic [5:0] F_SRAV = 6'b000111;
    localparam logic [5:0] F_JR   = 6'b001000;

    // One-hot bit positions in the decoded instruction vector
    localparam int IDX_ADD   = 0;
    localparam int IDX_ADDU  = 1;
    localparam int IDX_SUB   = 2;
    localparam int IDX_SUBU  = 3;
    localparam int IDX_AND   = 4;
    localparam int IDX_OR    = 5;
    localparam int IDX_XOR   = 6;
    localparam int IDX_NOR   = 7;
    localparam int IDX_SLT   = 8;
    localparam int IDX_SLTU  = 9;
    localparam int IDX_SLL   = 10;
    localparam int IDX_SRL   = 11;
    localparam int IDX_SRA   = 12;
    localparam int IDX_SLLV  = 13;
    localparam int IDX_SRLV  = 14;
    localparam int IDX_SRAV  = 15;
    localparam int IDX_JR    = 16;
    localparam int IDX_ADDI  = 17;
    localparam int IDX_ADDIU = 18;
    localparam int IDX_ANDI  = 19;
    localparam int IDX_ORI   = 20;
    localparam int IDX_XORI  = 21;
    localparam int IDX_LW    = 22;
    localparam int IDX_SW    = 23;
    localparam int IDX_BEQ   = 24;
    localparam int IDX_BNE   = 25;
    localparam int IDX_SLTI  = 26;
    localparam int IDX_SLTIU = 27;
    localparam int IDX_LUI   = 28;
    localparam int IDX_J     = 29;
    localparam int IDX_JAL   = 30;

endpackage

// File: rtl/instr_onehot_decode.sv
// Combinational instruction decoder: opcode/funct to a one-hot vector.
// An all-zero vector means the encoding is not one of the 31 supported ops.
module instr_onehot_decode
    import cpu31_pkg::*;
(
    input  logic [31:0]           instr,
    output logic [NUM_INSTR-1:0]  onehot,
    output logic                  illegal
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_fields;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    // Register and immediate fields play no part in decode.
    assign unused_fields = ^instr[25:6];

    // Map opcode (and funct for R-type) to exactly one set bit, or none.
    always_comb begin
        // NOTE: default assignment first so every path drives onehot; no latch.
        onehot = '0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    F_ADD:   onehot[IDX_ADD]  = 1'b1;
                    F_ADDU:  onehot[IDX_ADDU] = 1'b1;
                    F_SUB:   onehot[IDX_SUB]  = 1'b1;
                    F_SUBU:  onehot[IDX_SUBU] = 1'b1;
                    F_AND:   onehot[IDX_AND]  = 1'b1;
                    F_OR:    onehot[IDX_OR]   = 1'b1;
                    F_XOR:   onehot[IDX_XOR]  = 1'b1;
                    F_NOR:   onehot[IDX_NOR]  = 1'b1;
                    F_SLT:   onehot[IDX_SLT]  = 1'b1;
                    F_SLTU:  onehot[IDX_SLTU] = 1'b1;
                    F_SLL:   onehot[IDX_SLL]  = 1'b1;
                    F_SRL:   onehot[IDX_SRL]  = 1'b1;
                    F_SRA:   onehot[IDX_SRA]  = 1'b1;
                    F_SLLV:  onehot[IDX_SLLV] = 1'b1;
                    F_SRLV:  onehot[IDX_SRLV] = 1'b1;
                    F_SRAV:  onehot[IDX_SRAV] = 1'b1;
                    F_JR:    onehot[IDX_JR]   = 1'b1;
                    default: ;
                endcase
            end
            OP_ADDI:  onehot[IDX_ADDI]  = 1'b1;
            OP_ADDIU: onehot[IDX_ADDIU] = 1'b1;
            OP_ANDI:  onehot[IDX_ANDI]  = 1'b1;
            OP_ORI:   onehot[IDX_ORI]   = 1'b1;
            OP_XORI:  onehot[IDX_XORI]  = 1'b1;
            OP_LW:    onehot[IDX_LW]    = 1'b1;
            OP_SW:    onehot[IDX_SW]    = 1'b1;
            OP_BEQ:   onehot[IDX_BEQ]   = 1'b1;
            OP_BNE:   onehot[IDX_BNE]   = 1'b1;
            OP_SLTI:  onehot[IDX_SLTI]  = 1'b1;
            OP_SLTIU: onehot[IDX_SLTIU] = 1'b1;
            OP_LUI:   onehot[IDX_LUI]   = 1'b1;
            OP_J:     onehot[IDX_J]     = 1'b1;
            OP_JAL:   onehot[IDX_JAL]   = 1'b1;
            default:  ;
        endcase
    end

    assign illegal = (onehot == '0);

endmodule

// File: rtl/instr_decode_stage.sv
// Registered decode stage feeding the single-cycle controller: decodes the
// fetched word to a one-hot vector and holds it under stall/flush control,
// flagging and counting illegal encodings.
module instr_decode_stage
    import cpu31_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           instr_in,
    input  logic [31:0]           pc_in,
    input  logic                  in_valid,
    input  logic                  stall,
    input  logic                  flush,
    output logic [NUM_INSTR-1:0]  i_dec,
    output logic [31:0]           instr_out,
    output logic [31:0]           pc_out,
    output logic                  out_valid,
    output logic                  illegal,
    output logic [CNT_W-1:0]      illegal_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [NUM_INSTR-1:0] dec_onehot;
    logic                 dec_illegal;

    logic [NUM_INSTR-1:0] i_dec_d,       i_dec_q;
    logic [31:0]          instr_d,       instr_q;
    logic [31:0]          pc_d,          pc_q;
    logic                 valid_d,       valid_q;
    logic                 illegal_d,     illegal_q;
    logic [CNT_W-1:0]     illegal_cnt_d, illegal_cnt_q;

    instr_onehot_decode u_decode (
        .instr   (instr_in),
        .onehot  (dec_onehot),
        .illegal (dec_illegal)
    );

    // Next-state: flush clears, stall holds, otherwise load the new word.
    always_comb begin
        i_dec_d       = i_dec_q;
        instr_d       = instr_q;
        pc_d          = pc_q;
        valid_d       = valid_q;
        illegal_d     = illegal_q;
        illegal_cnt_d = illegal_cnt_q;
        if (flush) begin
            i_dec_d   = '0;
            instr_d   = '0;
            pc_d      = '0;
            valid_d   = 1'b0;
            illegal_d = 1'b0;
        end else if (!stall) begin
            instr_d = instr_in;
            pc_d    = pc_in;
            valid_d = in_valid;
            if (in_valid) begin
                i_dec_d   = dec_onehot;
                illegal_d = dec_illegal;
                // Saturate rather than wrap so a flood of bad words stays visible.
                if (dec_illegal && (illegal_cnt_q != CNT_MAX)) begin
                    illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
                end
            end else begin
                i_dec_d   = '0;
                illegal_d = 1'b0;
            end
        end
    end

    // Output registers with synchronous reset taking priority over all controls.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_dec_q       <= '0;
            instr_q       <= '0;
            pc_q          <= '0;
            valid_q       <= 1'b0;
            illegal_q     <= 1'b0;
            illegal_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            i_dec_q       <= i_dec_d;
            instr_q       <= instr_d;
            pc_q          <= pc_d;
            valid_q       <= valid_d;
            illegal_q     <= illegal_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign i_dec       = i_dec_q;
    assign instr_out   = instr_q;
    assign pc_out      = pc_q;
    assign out_valid   = valid_q;
    assign illegal     = illegal_q;
    assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboard bench for instr_decode_stage: the stimulus side updates a
// behavioural model and queues the expected register contents per edge;
// the monitor pops and compares one entry after every rising edge.
module tb_instr_decode_stage;

    localparam int CNT_W   = 8;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       instr_in;
    logic [31:0]       pc_in;
    logic              in_valid;
    logic              stall;
    logic              flush;
    logic [30:0]       i_dec;
    logic [31:0]       instr_out;
    logic [31:0]       pc_out;
    logic              out_valid;
    logic              illegal;
    logic [CNT_W-1:0]  illegal_cnt;

    instr_decode_stage #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_in    (instr_in),
        .pc_in       (pc_in),
        .in_valid    (in_valid),
        .stall       (stall),
        .flush       (flush),
        .i_dec       (i_dec),
        .instr_out   (instr_out),
        .pc_out      (pc_out),
        .out_valid   (out_valid),
        .illegal     (illegal),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [30:0] i_dec;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic        ill;
        int          cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t model;

    int checks = 0;
    int errors = 0;

    // Instruction table in bit order 0..30: opcode, and funct for R-type.
    logic [5:0] op_tab [0:30] = '{
        6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
        6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
        6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h04, 6'h05,
        6'h0A, 6'h0B, 6'h0F, 6'h02, 6'h03
    };
    logic [5:0] fn_tab [0:16] = '{
        6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
        6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08
    };

    // Returns the instruction's bit position, or -1 when it is not listed.
    function automatic int ref_decode(input logic [31:0] w);
        for (int i = 0; i < 31; i++) begin
            if (op_tab[i] == w[31:26]) begin
                if (i > 16) return i;
                if (fn_tab[i] == w[5:0]) return i;
            end
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge of stimulus: drive inputs, advance the model, queue expectation.
    task automatic step(input logic r, input logic f, input logic s, input logic v,
                        input logic [31:0] w, input logic [31:0] pc);
        int idx;
        @(negedge clk);
        rst = r; flush = f; stall = s; in_valid = v; instr_in = w; pc_in = pc;
        if (r) begin
            model = '{i_dec: '0, instr: '0, pc: '0, valid: 1'b0, ill: 1'b0, cnt: 0};
        end else if (f) begin
            model.i_dec = '0; model.instr = '0; model.pc = '0;
            model.valid = 1'b0; model.ill = 1'b0;
        end else if (!s) begin
            model.instr = w;
            model.pc    = pc;
            model.valid = v;
            model.i_dec = '0;
            model.ill   = 1'b0;
            if (v) begin
                idx = ref_decode(w);
                if (idx >= 0) model.i_dec = 31'(1) << idx;
                else begin
                    model.ill = 1'b1;
                    if (model.cnt < CNT_SAT) model.cnt++;
                end
            end
        end
        exp_q.push_back(model);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          idx;
        w = $urandom;
        if ($urandom_range(0, 3) != 0) begin
            idx = $urandom_range(0, 30);
            w[31:26] = op_tab[idx];
            if (idx <= 16) w[5:0] = fn_tab[idx];
        end
        return w;
    endfunction

    // Monitor: compare registered outputs against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("i_dec",       32'(i_dec),       32'(e.i_dec));
                check("instr_out",   instr_out,        e.instr);
                check("pc_out",      pc_out,           e.pc);
                check("out_valid",   32'(out_valid),   32'(e.valid));
                check("illegal",     32'(illegal),     32'(e.ill));
                check("illegal_cnt", 32'(illegal_cnt), 32'(e.cnt));
                check("i_dec_onehot", 32'($countones(i_dec) <= 1), 32'(1));
            end
        end
    end

    // Hard time bound so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_cycles;
        model = '{i_dec: '0, instr: '0, pc: '0, valid: 1'b0, ill: 1'b0, cnt: 0};
        rst = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
        instr_in = '0; pc_in = '0;

        // Reset, then basic decodes: add, jal, lw.
        step(1, 0, 0, 0, 32'h0, 32'h0);
        step(1, 0, 0, 0, 32'h0, 32'h0);
        step(0, 0, 0, 1, 32'h0022_1820, 32'h0000_0100);
        step(0, 0, 0, 1, 32'h0C00_0010, 32'h0000_0104);
        step(0, 0, 0, 1, 32'h8C22_0004, 32'h0000_0108);
        step(0, 0, 0, 1, 32'h0000_0000, 32'h0000_010C);

        // Stall holds lw for three cycles, release loads add.
        step(0, 0, 0, 1, 32'h8C22_0004, 32'h0000_0110);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 32'h0022_1820, 32'h0000_0114);
        step(0, 0, 0, 1, 32'h0022_1820, 32'h0000_0114);

        // Flush beats stall; then a bubble load.
        step(0, 1, 1, 1, 32'h0022_1820, 32'h0000_0118);
        step(0, 0, 0, 0, 32'h0022_1820, 32'h0000_011C);

        // Illegal words, then saturation of the counter.
        step(0, 0, 0, 1, 32'hFC00_0000, 32'h0000_0120);
        step(0, 0, 0, 1, 32'h0000_0001, 32'h0000_0124);
        for (int i = 0; i < 300; i++) step(0, 0, 0, 1, 32'hFC00_0000 | (i << 6), 32'(i * 4));
        step(0, 0, 1, 1, 32'hFC00_0000, 32'h0000_0200);
        step(0, 1, 0, 1, 32'hFC00_0000, 32'h0000_0204);

        // Reset mid-operation with count 5, then normal decode resumes.
        step(1, 0, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 32'h0000_003F, 32'h0000_0300);
        step(0, 0, 0, 1, 32'h3C01_1234, 32'h0000_0304);
        step(0, 0, 0, 1, 32'hFC00_0000, 32'h0000_0308);
        step(1, 1, 1, 1, 32'h0022_1820, 32'h0000_030C);
        step(0, 0, 0, 1, 32'h0C00_0010, 32'h0000_0310);

        // Randomized traffic with occasional stall, flush, bubbles and reset.
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 4) != 0,
                 rand_instr(), $urandom);
        end

        // Drain the scoreboard within a bounded number of cycles.
        wait_cycles = 0;
        while (exp_q.size() != 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
- Registered decode stage directly upstream of the single-cycle controller.
- Takes the raw 32-bit instruction and PC from the fetch path and decodes it into the 31-bit one-hot instruction vector the controller consumes (bit order add..jal, 0..30).
- Registers that vector with valid/stall/flush control, and flags and counts illegal encodings.

Parameters:
- CNT_W, 8, width of the saturating illegal-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- instr_in  input  32  instruction word from instruction memory.
- pc_in  input  32  address of instr_in.
- in_valid  input  1  instr_in/pc_in hold a real instruction this cycle.
- stall  input  1  hold all output registers.
- flush  input  1  discard the current contents and insert a bubble; overrides stall.
- i_dec  output  31  registered one-hot decode, bit map below; drives controller input i.
- instr_out  output  32  registered instruction word, for immediate/register-field extraction.
- pc_out  output  32  registered PC.
- out_valid  output  1  the registered contents are a real instruction.
- illegal  output  1  the registered instruction failed decode.
- illegal_cnt  output  CNT_W  saturating count of illegal instructions loaded.

Behaviour:
- Reset (rst=1 at clk edge): i_dec=0, instr_out=0, pc_out=0, out_valid=0, illegal=0, illegal_cnt=0. Reset overrides flush and stall and applies mid-operation without exception.
- Priority per edge: rst > flush > stall > load.
- flush: out_valid=0, i_dec=0, illegal=0. instr_out and pc_out are don't-care and are cleared to 0. illegal_cnt is unchanged.
- stall (no flush): every output register holds its value, including illegal_cnt.
- load (neither flush nor stall):
  - Registers instr_out=instr_in, pc_out=pc_in and out_valid=in_valid.
  - If in_valid=0: i_dec=0 and illegal=0.
  - If in_valid=1: i_dec=decode(instr_in), and illegal=1 exactly when decode yields all-zero.
- Latency: exactly one cycle from instr_in to i_dec.
- Decode is combinational on opcode [31:26] and funct [5:0].
- R-type (opcode 000000), by funct:
  - add 100000→b0, addu 100001→b1, sub 100010→b2, subu 100011→b3
  - and 100100→b4, or 100101→b5, xor 100110→b6, nor 100111→b7
  - slt 101010→b8, sltu 101011→b9
  - sll 000000→b10, srl 000010→b11, sra 000011→b12
  - sllv 000100→b13, srlv 000110→b14, srav 000111→b15, jr 001000→b16
- Other opcodes:
  - addi 001000→b17, addiu 001001→b18, andi 001100→b19, ori 001101→b20, xori 001110→b21
  - lw 100011→b22, sw 101011→b23, beq 000100→b24, bne 000101→b25
  - slti 001010→b26, sltiu 001011→b27, lui 001111→b28, j 000010→b29, jal 000011→b30
- No other field is checked. 0x00000000 decodes as legal sll (b10) and serves as the NOP.
- i_dec is strictly one-hot or all-zero; never two bits set.
- Any unlisted opcode, or an unlisted funct under opcode 0, is illegal. The stage then emits i_dec=0, out_valid=in_valid and illegal=1, so the downstream controller sees a bubble with RF_W asserted on no valid op.
- illegal_cnt increments by 1 on each load edge where illegal becomes 1. It saturates at 2^CNT_W-1 and does not wrap.

Decomposition:
- Shared package cpu31_pkg holds:
  - opcode and funct localparams for all 31 instructions;
  - one-hot bit-index constants IDX_ADD..IDX_JAL (0..30), also used by the controller;
  - NUM_INSTR=31.
- Sub-module instr_onehot_decode: purely combinational, instr[31:0] → onehot[30:0] plus illegal. It is verified standalone, and this stage adds only the register and control logic.

Test Plan:
1. rst 2 cycles, then instr_in=0x00221820 (add), in_valid=1 → next cycle i_dec=31'h0000_0001, out_valid=1, illegal=0, pc_out=pc_in.
2. instr_in=0x0C000010 (jal) → i_dec=31'h4000_0000. Then instr_in=0x8C220004 (lw) → i_dec=31'h0040_0000.
3. Load lw, then stall=1 for 3 cycles while instr_in=0x00221820 → i_dec stays 31'h0040_0000 and instr_out stays 0x8C220004. Releasing stall loads add the next edge.
4. stall=1 and flush=1 together → out_valid=0, i_dec=0. A subsequent in_valid=0 load → out_valid=0, i_dec=0.
5. instr_in=0xFC000000 and 0x00000001 (funct 000001) → illegal=1, i_dec=0, illegal_cnt 0→1→2. 300 consecutive illegals → illegal_cnt holds at 255.
6. Assert rst while out_valid=1 and illegal_cnt=5 → next edge all outputs 0, and decode resumes normally the cycle after release.
